// File: rtl/intra_mbaddrb_ram_writer_pkg.sv
// Shared defines for the Intra mbAddrB RAM writer: bottom-edge block IDs,
// chroma base addresses, FSM encoding and the pending-write payload.
package intra_mbaddrb_ram_writer_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BLK_W  = 5;

   // 4x4 blocks whose bottom pixel row is consumed by the MB below
   localparam logic [BLK_W-1:0] BLK_Y_10  = 5'd10;
   localparam logic [BLK_W-1:0] BLK_Y_11  = 5'd11;
   localparam logic [BLK_W-1:0] BLK_Y_14  = 5'd14;
   localparam logic [BLK_W-1:0] BLK_Y_15  = 5'd15;
   localparam logic [BLK_W-1:0] BLK_CB_18 = 5'd18;
   localparam logic [BLK_W-1:0] BLK_CB_19 = 5'd19;
   localparam logic [BLK_W-1:0] BLK_CR_22 = 5'd22;
   localparam logic [BLK_W-1:0] BLK_CR_23 = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } wr_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

   function automatic logic is_bottom_blk(input logic [BLK_W-1:0] blk);
      case (blk)
         BLK_Y_10, BLK_Y_11, BLK_Y_14, BLK_Y_15,
         BLK_CB_18, BLK_CB_19, BLK_CR_22, BLK_CR_23: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   // Cb rows follow the 4*W luma words, Cr rows follow the 2*W Cb words
   function automatic logic [ADDR_W-1:0] cb_base(input int unsigned pic_w);
      return ADDR_W'(4 * pic_w);
   endfunction

   function automatic logic [ADDR_W-1:0] cr_base(input int unsigned pic_w);
      return ADDR_W'(6 * pic_w);
   endfunction

endpackage

// File: rtl/intra_mbaddrb_wr_fifo.sv
// Pending-write buffer; when empty a simultaneous push+pop bypasses storage
// so the head is the incoming entry.
module intra_mbaddrb_wr_fifo
   import intra_mbaddrb_ram_writer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      i_push,
   input  logic      i_pop,
   input  wr_entry_t i_data,
   output wr_entry_t o_head_c,
   output logic      o_empty_c,
   output logic      o_drained_c,
   output logic      o_full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   wr_entry_t         r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic              r_full;

   logic              w_bypass;
   logic              w_store;
   logic              w_take;
   logic [CW-1:0]     w_count_nxt;

   assign o_empty_c   = (r_count == '0);
   assign w_bypass    = o_empty_c && i_push && i_pop;
   assign w_store     = i_push && !w_bypass && (!r_full || i_pop);
   assign w_take      = i_pop && !o_empty_c;
   assign w_count_nxt = r_count + CW'(w_store) - CW'(w_take);
   assign o_head_c    = o_empty_c ? i_data : r_mem[r_rd_ptr];
   assign o_drained_c = (w_count_nxt == '0);
   assign o_full      = r_full;

   // Pointers are power-of-two wide, so they wrap modulo DEPTH naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_store) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_take) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/intra_mbaddrb_ram_writer.sv
// Captures the bottom pixel row of each edge 4x4 block and writes it to the
// Intra mbAddrB RAM. Define INTRA_MBADDRB_LASTROW_SKIP_EN to skip the last MB row.
module intra_mbaddrb_ram_writer
   import intra_mbaddrb_ram_writer_pkg::*;
#(
   parameter int unsigned PIC_WIDTH_MB  = 11,
   parameter int unsigned PIC_HEIGHT_MB = 9,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        mb_num_h,
   input  logic [3:0]        mb_num_v,
   input  logic [4:0]        blk4x4_rec_counter,
   input  logic [2:0]        blk4x4_sum_counter,
   input  logic              sum_valid,
   input  logic [7:0]        blk4x4_sum_PE0_out,
   input  logic [7:0]        blk4x4_sum_PE1_out,
   input  logic [7:0]        blk4x4_sum_PE2_out,
   input  logic [7:0]        blk4x4_sum_PE3_out,
   input  logic              wr_stall,
   output logic              Intra_mbAddrB_RAM_wr,
   output logic [ADDR_W-1:0] Intra_mbAddrB_RAM_wr_addr,
   output logic [DATA_W-1:0] Intra_mbAddrB_RAM_din,
   output logic              fifo_full,
   output logic              busy,
   output logic              overflow_err
);

   localparam logic [ADDR_W-1:0] CB_BASE = cb_base(PIC_WIDTH_MB);
   localparam logic [ADDR_W-1:0] CR_BASE = cr_base(PIC_WIDTH_MB);

   wr_state_e         r_state;
   logic              r_busy;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;
   logic              r_overflow;

   logic              w_row_ok;
   logic              w_push;
   logic              w_pop;
   logic [1:0]        w_col;
   logic [ADDR_W-1:0] w_addr;
   wr_entry_t         w_new;
   wr_entry_t         w_head;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic              w_drained;

`ifdef INTRA_MBADDRB_LASTROW_SKIP_EN
   assign w_row_ok = (mb_num_v != 4'(PIC_HEIGHT_MB - 1));
`else
   logic w_unused;
   assign w_row_ok = 1'b1;
   assign w_unused = ^{mb_num_v, 4'(PIC_HEIGHT_MB)};
`endif

   assign w_push = sum_valid && (blk4x4_sum_counter == 3'd3) &&
                   is_bottom_blk(blk4x4_rec_counter) && w_row_ok;

   // Luma has four bottom columns per MB, chroma two; bit 2 selects Cr over Cb
   assign w_col = blk4x4_rec_counter[4] ? {1'b0, blk4x4_rec_counter[0]}
                                        : {blk4x4_rec_counter[2], blk4x4_rec_counter[0]};

   always_comb begin
      w_addr = ADDR_W'({mb_num_h, w_col});
      if (blk4x4_rec_counter[4]) begin
         w_addr = (blk4x4_rec_counter[2] ? CR_BASE : CB_BASE)
                + ADDR_W'({mb_num_h, 1'b0}) + ADDR_W'(w_col);
      end
   end

   assign w_new.addr = w_addr;
   assign w_new.data = {blk4x4_sum_PE3_out, blk4x4_sum_PE2_out,
                        blk4x4_sum_PE1_out, blk4x4_sum_PE0_out};
   assign w_pop      = !wr_stall && (!w_fifo_empty || w_push);

   intra_mbaddrb_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_data      (w_new),
      .o_head_c    (w_head),
      .o_empty_c   (w_fifo_empty),
      .o_drained_c (w_drained),
      .o_full      (w_fifo_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_din      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr <= w_pop;
         if (w_pop) begin
            r_addr <= w_head.addr;
            r_din  <= w_head.data;
         end
         if (w_push && w_fifo_full && wr_stall) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_push) begin
                  r_state <= ST_DRAIN;
                  r_busy  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_drained) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (wr_stall) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!wr_stall) begin
                  r_state <= ST_DRAIN;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Intra_mbAddrB_RAM_wr      = r_wr;
   assign Intra_mbAddrB_RAM_wr_addr = r_addr;
   assign Intra_mbAddrB_RAM_din     = r_din;
   assign fifo_full                 = w_fifo_full;
   assign busy                      = r_busy;
   assign overflow_err              = r_overflow;

endmodule

// File: tb/tb_intra_mbaddrb_ram_writer.sv
// Bench for intra_mbaddrb_ram_writer: directed steps then random traffic,
// checked against a queue model of the pending writes.
module tb_intra_mbaddrb_ram_writer;

   localparam int W = 11;
   localparam int H = 9;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  mb_num_h = '0;
   logic [3:0]  mb_num_v = '0;
   logic [4:0]  blk = '0;
   logic [2:0]  row = '0;
   logic        sum_valid = 1'b0;
   logic [7:0]  pe0 = '0, pe1 = '0, pe2 = '0, pe3 = '0;
   logic        wr_stall = 1'b0;
   logic        wr;
   logic [6:0]  wr_addr;
   logic [31:0] din;
   logic        fifo_full;
   logic        busy;
   logic        overflow_err;

   always #5 clk = ~clk;

   intra_mbaddrb_ram_writer #(
      .PIC_WIDTH_MB (W),
      .PIC_HEIGHT_MB(H),
      .FIFO_DEPTH   (D)
   ) dut (
      .clk                       (clk),
      .reset                     (reset),
      .mb_num_h                  (mb_num_h),
      .mb_num_v                  (mb_num_v),
      .blk4x4_rec_counter        (blk),
      .blk4x4_sum_counter        (row),
      .sum_valid                 (sum_valid),
      .blk4x4_sum_PE0_out        (pe0),
      .blk4x4_sum_PE1_out        (pe1),
      .blk4x4_sum_PE2_out        (pe2),
      .blk4x4_sum_PE3_out        (pe3),
      .wr_stall                  (wr_stall),
      .Intra_mbAddrB_RAM_wr      (wr),
      .Intra_mbAddrB_RAM_wr_addr (wr_addr),
      .Intra_mbAddrB_RAM_din     (din),
      .fifo_full                 (fifo_full),
      .busy                      (busy),
      .overflow_err              (overflow_err)
   );

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] data;
   } ent_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   ent_t        q[$];
   logic        m_wr   = 1'b0;
   logic [6:0]  m_addr = '0;
   logic [31:0] m_din  = '0;
   logic        m_ovf  = 1'b0;
   logic        m_full = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic m_capture(input int v, input int b, input int r, input logic valid);
      logic bottom;
      bottom = (b == 10 || b == 11 || b == 14 || b == 15 ||
                b == 18 || b == 19 || b == 22 || b == 23);
`ifdef INTRA_MBADDRB_LASTROW_SKIP_EN
      if (v == H - 1) return 1'b0;
`else
      if (v < 0) return 1'b0;
`endif
      return valid && (r == 3) && bottom;
   endfunction

   function automatic logic [6:0] m_address(input int h, input int b);
      int col;
      if (b < 16) begin
         col = ((b / 4) % 2) * 2 + (b % 2);
         return 7'(h * 4 + col);
      end
      if (b < 20) return 7'(4 * W + h * 2 + (b % 2));
      return 7'(6 * W + h * 2 + (b % 2));
   endfunction

   // One clock: drive inputs, advance, update the model, compare outputs
   task automatic step(input int h, input int v, input int b, input int r,
                       input logic valid, input logic [31:0] pes, input logic stall);
      logic push;
      ent_t e;
      ent_t hd;
      mb_num_h  = 4'(h);
      mb_num_v  = 4'(v);
      blk       = 5'(b);
      row       = 3'(r);
      sum_valid = valid;
      pe0 = pes[7:0]; pe1 = pes[15:8]; pe2 = pes[23:16]; pe3 = pes[31:24];
      wr_stall  = stall;
      @(posedge clk); #1;
      push   = m_capture(v, b, r, valid);
      e.addr = m_address(h, b);
      e.data = pes;
      m_wr   = 1'b0;
      if (stall) begin
         if (push) begin
            if (q.size() < D) q.push_back(e);
            else m_ovf = 1'b1;
         end
      end else begin
         if (push) q.push_back(e);
         if (q.size() > 0) begin
            hd     = q.pop_front();
            m_wr   = 1'b1;
            m_addr = hd.addr;
            m_din  = hd.data;
         end
      end
      m_full = (q.size() == D);
      chk("wr", 32'(wr), 32'(m_wr));
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("din", din, m_din);
      chk("fifo_full", 32'(fifo_full), 32'(m_full));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
   endtask

   task automatic idle(input logic stall);
      step(0, 0, 0, 0, 1'b0, 32'h0, stall);
   endtask

   task automatic do_reset(input int cycles);
      reset     = 1'b1;
      sum_valid = 1'b1;
      blk       = 5'd15;
      row       = 3'd3;
      repeat (cycles) @(posedge clk);
      #1;
      chk("rst_wr", 32'(wr), 32'h0);
      chk("rst_addr", 32'(wr_addr), 32'h0);
      chk("rst_din", din, 32'h0);
      chk("rst_full", 32'(fifo_full), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ovf", 32'(overflow_err), 32'h0);
      reset     = 1'b0;
      sum_valid = 1'b0;
      q.delete();
      m_wr = 1'b0; m_addr = '0; m_din = '0; m_ovf = 1'b0; m_full = 1'b0;
   endtask

   initial begin
      int b;
      do_reset(2);

      // Single luma capture, bypass path
      step(2, 0, 14, 3, 1'b1, 32'h44332211, 1'b0);
      chk("luma_wr", 32'(wr), 32'h1);
      chk("luma_addr", 32'(wr_addr), 32'd10);
      chk("luma_din", din, 32'h44332211);
      chk("luma_busy", 32'(busy), 32'h1);
      idle(1'b0);
      chk("idle_wr", 32'(wr), 32'h0);

      // Cr block at the right-most MB
      step(10, 0, 23, 3, 1'b1, 32'hA1B2C3D4, 1'b0);
      chk("cr_addr", 32'(wr_addr), 32'd87);
      idle(1'b0);

      // Non-final rows and a non-bottom block
      for (int r = 0; r < 3; r++) step(2, 0, 14, r, 1'b1, 32'h5555AAAA, 1'b0);
      step(2, 0, 5, 3, 1'b1, 32'h12345678, 1'b0);
      chk("nocap_wr", 32'(wr), 32'h0);
      step(2, 0, 14, 3, 1'b0, 32'h12345678, 1'b0);

      // Stall with five captures: fifth one dropped
      step(1, 0, 10, 3, 1'b1, 32'h01010101, 1'b1);
      step(1, 0, 11, 3, 1'b1, 32'h02020202, 1'b1);
      step(1, 0, 14, 3, 1'b1, 32'h03030303, 1'b1);
      step(1, 0, 15, 3, 1'b1, 32'h04040404, 1'b1);
      step(1, 0, 18, 3, 1'b1, 32'h05050505, 1'b1);
      chk("ovf_full", 32'(fifo_full), 32'h1);
      chk("ovf_sticky", 32'(overflow_err), 32'h1);
      chk("ovf_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 4; i++) begin
         idle(1'b0);
         chk("drain_wr", 32'(wr), 32'h1);
      end
      repeat (3) idle(1'b0);
      chk("drained_busy", 32'(busy), 32'h0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(3, 1, 19, 3, 1'b1, 32'(i * 32'h11), 1'b1);
      step(4, 1, 22, 3, 1'b1, 32'hCAFEF00D, 1'b0);
      chk("pushpop_full", 32'(fifo_full), 32'h1);
      repeat (6) idle(1'b0);

      // Reset with pending entries
      for (int i = 0; i < 3; i++) step(5, 2, 10 + i, 3, 1'b1, 32'(32'hBEEF0000 + i), 1'b1);
      do_reset(1);
      repeat (4) idle(1'b0);

      // Last MB row
      step(6, H - 1, 15, 3, 1'b1, 32'h0F0E0D0C, 1'b0);
`ifdef INTRA_MBADDRB_LASTROW_SKIP_EN
      chk("lastrow_wr", 32'(wr), 32'h0);
`else
      chk("lastrow_wr", 32'(wr), 32'h1);
`endif
      step(6, H - 2, 15, 3, 1'b1, 32'h0B0A0908, 1'b0);
      chk("row7_wr", 32'(wr), 32'h1);

      // Random traffic
      do_reset(1);
      repeat (400) begin
         if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 7))
               0: b = 10; 1: b = 11; 2: b = 14; 3: b = 15;
               4: b = 18; 5: b = 19; 6: b = 22; default: b = 23;
            endcase
         end else begin
            b = int'($urandom_range(0, 23));
         end
         step(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), b,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 3) == 0));
      end
      repeat (8) idle(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
